tlp_tx_packer: RTL
==================

// Module: tlp_tx_packer
// PURPOSE
//  Downstream of the AXI-write-to-TLP stage. Takes one complete TLP (4DW memory-request header + up to 1024b payload).
//  Serialises it onto a 256b beat stream (header first, payload packed immediately behind) with sop/eop/DW-keep.
//  The stream feeds the data-link framing stage.
//  Single packet in flight; back-to-back packets with zero bubble.
// PARAMETERS
//  DATA_WIDTH       256  output beat width in bits (8 DW); only 256 supported
//  CHUNK_MAX_BEATS  4    max payload beats on input (1024b = 32 DW)
//  HDR_DW           4    header length in DW (3DW headers not supported)
// PORTS
//  clk            in   1     clock
//  rst            in   1     asynchronous reset, active-high
//  tlp_valid_i    in   1     input TLP valid
//  tlp_ready_o    out  1     input TLP accepted when valid&ready
//  tlp_hdr_i      in   128   tlp_memory_req_header (PCIE_PKG)
//  tlp_payload_i  in   1024  payload; beat j = [1023-256*j -: 256], DW k of beat at [32k+:32]
//  tlp_len_dw_i   in   6     payload length in DW, 0 (no data) .. 32
//  out_valid_o    out  1     output beat valid
//  out_ready_i    in   1     downstream accepts beat when valid&ready
//  out_data_o     out  256   beat data; stream DW n of beat i at [32*(n-8i)+:32]
//  out_keep_o     out  8     per-DW enable of out_data_o
//  out_sop_o      out  1     first beat of packet
//  out_eop_o      out  1     last beat of packet
//  err_len_o      out  1     sticky: tlp_len_dw_i > 32 was accepted
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, except tlp_ready_o=1; FSM=IDLE; shift reg, counters, err cleared.
//  Reset mid-packet: remaining beats dropped and never resumed.
//  Stream layout: stream DW 0..3 = header DW0..3 (hdr[31:0] first); DW 4+m = payload DW m.
//  Total DW T = 4+len; beats N = ceil(T/8) (len 0..4 ->1, 5..12 ->2, ..., 29..32 ->5).
//  Last-beat keep = (T%8==0) ? 8'hFF : (8'h1<<(T%8))-1; all other beats keep=8'hFF.
//  Length rule: len>32 is treated as 32 and sets err_len_o until reset.
//  FSM IDLE:
//   - tlp_ready_o=1.
//   - On accept: load 1280b shift reg {payload reordered, hdr}, beat_cnt=N-1 (3b), go SEND.
//   - Latency: beat 0 appears on out_*_o in the cycle after accept (registered outputs).
//  FSM SEND:
//   - out_valid_o=1.
//   - On out_ready_i: shift reg >>256, beat_cnt--.
//   - sop=1 only on beat 0; eop=1 when beat_cnt==0; N=1 gives sop&eop together.
//  Stall: while out_valid_o & !out_ready_i, data/keep/sop/eop held bit-stable.
//  Back-to-back:
//   - tlp_ready_o = IDLE | (SEND & eop & out_ready_i).
//   - An accept in that same cycle reloads and stays in SEND, so the next sop follows eop with no gap.
//   - Otherwise eop&ready returns the FSM to IDLE.
//  Input contract: tlp_* stable while valid & !ready. Payload DWs beyond len are ignored; keep marks them off.
//  No combinational path from out_ready_i to out_data_o; tlp_ready_o depends on out_ready_i (documented).
// STRUCTURE
//  PCIE_PKG: tlp_memory_req_header (existing); add TLP_HDR_DW=4, TLP_MAX_PAYLOAD_DW=32.
//  PCIE_PKG: add function tlp_num_beats(len) and function tlp_last_keep(len); the bench shares both.
//  Single module, no sub-module: FSM (IDLE/SEND) + 1280b shift reg + 3b beat counter + err flop.
// TESTING
//  1. hdr=H, len=32, payload=P, out_ready=1:
//     -> 5 beats with sop on beat0 and eop on beat4; beat0=[P.dw3..0,H]; beat4 keep=8'h0F.
//  2. len=0 (MemRead header only) -> 1 beat, sop=eop=1, keep=8'h0F, data[127:0]=H.
//  3. len=4 and len=12 -> 1 beat keep=8'hFF; 2 beats, last keep=8'hFF.
//  4. out_ready toggled 1010.. mid-packet -> each beat held stable while stalled; no beat lost or duplicated.
//  5. Two TLPs presented continuously:
//     -> second sop on the cycle right after first eop; tlp_ready pulses on the eop cycle only.
//  6. rst=1 during beat 2 -> out_valid=0 immediately; after release next TLP streams normally.
//  7. len=40 -> treated as 32 (5 beats), err_len_o=1 and stays 1 until rst.

Source files
------------

// File: rtl/tlp_tx_packer_pkg.sv
// Shared TLP definitions for the transmit path: memory-request header layout,
// header/payload size constants and beat-count / last-beat keep helpers.
package tlp_tx_packer_pkg;

    localparam int TLP_HDR_DW         = 4;
    localparam int TLP_MAX_PAYLOAD_DW = 32;
    localparam int TLP_BEAT_DW        = 8;

    // 4DW memory request header, DW0 in the low 32 bits.
    typedef struct packed {
        logic [63:0] addr;
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic [3:0]  last_be;
        logic [3:0]  first_be;
        logic [2:0]  fmt;
        logic [4:0]  tlp_type;
        logic [2:0]  tc;
        logic [2:0]  attr;
        logic [7:0]  rsvd;
        logic [9:0]  length;
    } tlp_memory_req_header;

    // Header plus payload DWs; oversize lengths are clamped to the maximum.
    function automatic logic [6:0] tlp_total_dw(input logic [5:0] len_dw);
        logic [5:0] eff;
        eff = (len_dw > 6'(TLP_MAX_PAYLOAD_DW)) ? 6'(TLP_MAX_PAYLOAD_DW) : len_dw;
        return 7'(TLP_HDR_DW) + {1'b0, eff};
    endfunction

    // Number of 8DW beats needed to carry the whole packet (1..5).
    function automatic logic [2:0] tlp_num_beats(input logic [5:0] len_dw);
        logic [6:0] t;
        t = tlp_total_dw(len_dw);
        return 3'((t + 7'd7) >> 3);
    endfunction

    // DW enables of the final beat; a full final beat enables all 8 DWs.
    function automatic logic [7:0] tlp_last_keep(input logic [5:0] len_dw);
        logic [6:0] t;
        logic [2:0] r;
        t = tlp_total_dw(len_dw);
        r = t[2:0];
        if (r == 3'd0) begin
            return 8'hFF;
        end
        return (8'h01 << r) - 8'h01;
    endfunction

endpackage

// File: rtl/tlp_tx_packer.sv
// Serialises one complete TLP (4DW header + up to 32DW payload) onto a 256b
// beat stream with sop/eop/keep. One packet in flight; a new packet can be
// accepted on the eop handshake cycle so packets follow with no bubble.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high. Producers hold data stable while valid & !ready. tlp_ready_o is
// combinationally dependent on out_ready_i (ready during the eop handshake);
// out_data_o/keep/sop/eop come only from registers.
module tlp_tx_packer
    import tlp_tx_packer_pkg::*;
#(
    parameter int DATA_WIDTH      = 256,
    parameter int CHUNK_MAX_BEATS = 4,
    parameter int HDR_DW          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tlp_valid_i,
    output logic                      tlp_ready_o,
    input  tlp_memory_req_header      tlp_hdr_i,
    input  logic [1023:0]             tlp_payload_i,
    input  logic [5:0]                tlp_len_dw_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_WIDTH-1:0]     out_data_o,
    output logic [DATA_WIDTH/32-1:0]  out_keep_o,
    output logic                      out_sop_o,
    output logic                      out_eop_o,
    output logic                      err_len_o
);

    localparam int HDR_W   = HDR_DW * 32;
    localparam int SHREG_W = DATA_WIDTH * (CHUNK_MAX_BEATS + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                  state;
    logic [SHREG_W-1:0]      shreg;
    logic [2:0]              beat_cnt;
    logic [7:0]              last_keep;
    logic                    sop_q;
    logic                    err_q;
    logic [SHREG_W-1:0]      load_vec;
    logic                    last_beat;
    logic                    accept;

    assign last_beat   = (state == ST_SEND) && (beat_cnt == 3'd0);
    assign tlp_ready_o = (state == ST_IDLE) || (last_beat && out_ready_i);
    assign accept      = tlp_valid_i && tlp_ready_o;

    // Stream image of the packet: header DWs first, then payload DW m taken
    // from beat m/8, DW m%8 of the input payload bus.
    always_comb begin
        load_vec             = '0;
        load_vec[HDR_W-1:0]  = tlp_hdr_i;
        for (int m = 0; m < TLP_MAX_PAYLOAD_DW; m++) begin
            load_vec[HDR_W + 32*m +: 32] =
                tlp_payload_i[768 - 256*(m/8) + 32*(m%8) +: 32];
        end
    end

    // Packet FSM: load on accept, shift one beat per output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            beat_cnt  <= '0;
            last_keep <= '0;
            sop_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                state     <= ST_SEND;
                shreg     <= load_vec;
                beat_cnt  <= tlp_num_beats(tlp_len_dw_i) - 3'd1;
                last_keep <= tlp_last_keep(tlp_len_dw_i);
                sop_q     <= 1'b1;
                if (tlp_len_dw_i > 6'(TLP_MAX_PAYLOAD_DW)) begin
                    err_q <= 1'b1;
                end
            end else if ((state == ST_SEND) && out_ready_i) begin
                shreg    <= shreg >> DATA_WIDTH;
                beat_cnt <= beat_cnt - 3'd1;
                sop_q    <= 1'b0;
                if (beat_cnt == 3'd0) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    // Output decode purely from registered state.
    always_comb begin
        out_valid_o = (state == ST_SEND);
        out_data_o  = shreg[DATA_WIDTH-1:0];
        out_keep_o  = '0;
        if (state == ST_SEND) begin
            out_keep_o = (beat_cnt == 3'd0) ? last_keep : 8'hFF;
        end
        out_sop_o   = sop_q && (state == ST_SEND);
        out_eop_o   = last_beat;
        err_len_o   = err_q;
    end

endmodule
